// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared types and helpers for the stream demultiplexer.
//   state_t        - EMPTY / HOLD view of the pending mask (debug/coverage)
//   sel_in_range() - 1 when a select addresses an existing channel
package stream_demux_pkg;

   typedef enum logic {EMPTY, HOLD} state_t;

   function automatic logic sel_in_range(input int unsigned sel, input int unsigned channels);
      return sel < channels;
   endfunction

endpackage

// File: rtl/stream_demux_if.sv
// stream_demux_if: producer-side and consumer-side handshake bundle of stream_demux.
//   in_valid/in_ready/in_data/in_sel/in_bcast  - single producer
//   out_valid/out_ready/out_data               - per-channel consumers (data shared)
//   err_sel/drop_cnt                           - out-of-range select reporting
//   slave modport: block view; master modport: environment view.
interface stream_demux_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 8,
   parameter int CNT_W    = 16
);
   localparam int SEL_W = $clog2(CHANNELS);

   logic                in_valid;
   logic                in_ready;
   logic [WIDTH-1:0]    in_data;
   logic [SEL_W-1:0]    in_sel;
   logic                in_bcast;
   logic [CHANNELS-1:0] out_valid;
   logic [CHANNELS-1:0] out_ready;
   logic [WIDTH-1:0]    out_data;
   logic                err_sel;
   logic [CNT_W-1:0]    drop_cnt;

   modport slave (
      input  in_valid, in_data, in_sel, in_bcast, out_ready,
      output in_ready, out_valid, out_data, err_sel, drop_cnt
   );

   modport master (
      output in_valid, in_data, in_sel, in_bcast, out_ready,
      input  in_ready, out_valid, out_data, err_sel, drop_cnt
   );

endinterface

// File: rtl/stream_demux_onehot_decode.sv
// onehot_decode: combinational select-to-mask decoder.
//   sel      - channel index
//   bcast    - 1 selects every channel
//   mask     - all-ones on bcast, one-hot(sel) when in range, else zero
//   in_range - sel addresses an existing channel (independent of bcast)
module onehot_decode
   import stream_demux_pkg::*;
#(
   parameter int N     = 8,
   parameter int SEL_W = $clog2(N)
) (
   input  logic [SEL_W-1:0] sel,
   input  logic             bcast,
   output logic [N-1:0]     mask,
   output logic             in_range
);

   always_comb begin
      in_range = sel_in_range(32'(sel), N);
      mask     = bcast ? '1 : in_range ? N'(1) << sel : '0;
   end

endmodule

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-CHANNELS valid/ready demultiplexer.
//   clk, rst - clock, synchronous active-high reset
//   bus      - stream_demux_if.slave: producer input, per-channel outputs,
//              out-of-range error pulse and saturating drop counter
module stream_demux
   import stream_demux_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 8,
   parameter int CNT_W    = 16
) (
   input  logic           clk,
   input  logic           rst,
   stream_demux_if.slave  bus
);

   localparam int SEL_W = $clog2(CHANNELS);

   logic [CHANNELS-1:0] pend_q, pend_d, rem, mask;
   logic [WIDTH-1:0]    data_q, data_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
   logic                in_range, in_ready, accept, drop;
   state_t              state;

   onehot_decode #(.N(CHANNELS), .SEL_W(SEL_W)) u_dec (
      .sel      (bus.in_sel),
      .bcast    (bus.in_bcast),
      .mask     (mask),
      .in_range (in_range)
   );

   always_comb begin
      state    = (pend_q != '0) ? HOLD : EMPTY;
      // channels still waiting after this cycle's completions
      rem      = pend_q & ~bus.out_ready;
      in_ready = (state == EMPTY) || (rem == '0);
      accept   = bus.in_valid && in_ready;
      drop     = accept && !bus.in_bcast && !in_range;
      // rem is zero whenever accept is high, so the new mask replaces it;
      // a dropped word decodes to an all-zero mask
      pend_d   = accept ? mask : rem;
      data_d   = (accept && !drop) ? bus.in_data : data_q;
      err_d    = drop;
      cnt_d    = (drop && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= '0;
         data_q <= '0;
         err_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         data_q <= data_d;
         err_q  <= err_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = pend_q;
   assign bus.out_data  = data_q;
   assign bus.err_sel   = err_q;
   assign bus.drop_cnt  = cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed self-checking bench for stream_demux (8- and 6-channel instances).
module tb_stream_demux;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   stream_demux_if #(.WIDTH(8), .CHANNELS(8), .CNT_W(16)) b8 ();
   stream_demux_if #(.WIDTH(8), .CHANNELS(6), .CNT_W(16)) b6 ();

   stream_demux #(.WIDTH(8), .CHANNELS(8), .CNT_W(16)) u8 (.clk(clk), .rst(rst), .bus(b8));
   stream_demux #(.WIDTH(8), .CHANNELS(6), .CNT_W(16)) u6 (.clk(clk), .rst(rst), .bus(b6));

   typedef struct {logic [7:0] d; logic [7:0] m;} exp_t;
   exp_t sb[$];

   int total = 0;
   int passed = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d, input logic [7:0] m);
      exp_t e;
      e.d = d;
      e.m = m;
      sb.push_back(e);
   endtask

   task automatic pop_chk(input string tag);
      exp_t e;
      total++;
      assert (sb.size() != 0) passed++;
      else $error("FAIL %s_sb observed=empty expected=entry", tag);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_valid"}, 32'(b8.out_valid), 32'(e.m));
         chk({tag, "_data"}, 32'(b8.out_data), 32'(e.d));
      end
   endtask

   task automatic drv8(input logic v, input logic [7:0] d, input logic [2:0] s, input logic b, input logic [7:0] r);
      b8.in_valid  = v;
      b8.in_data   = d;
      b8.in_sel    = s;
      b8.in_bcast  = b;
      b8.out_ready = r;
   endtask

   initial begin
      rst = 1'b1;
      drv8(1'b0, 8'h00, 3'd0, 1'b0, 8'hFF);
      b6.in_valid  = 1'b0;
      b6.in_data   = 8'h00;
      b6.in_sel    = 3'd0;
      b6.in_bcast  = 1'b0;
      b6.out_ready = 6'h3F;
      step();
      step();
      rst = 1'b0;
      step();
      chk("rst_valid", 32'(b8.out_valid), 32'h00);
      chk("rst_data", 32'(b8.out_data), 32'h00);
      chk("rst_ready", 32'(b8.in_ready), 32'h1);
      chk("rst_cnt", 32'(b8.drop_cnt), 32'h0);
      chk("rst_err", 32'(b8.err_sel), 32'h0);
      chk("rst6_cnt", 32'(b6.drop_cnt), 32'h0);

      // directed routing with backpressure
      drv8(1'b1, 8'hA5, 3'd3, 1'b0, 8'hFF);
      push(8'hA5, 8'h08);
      step();
      b8.in_valid = 1'b0;
      pop_chk("route");
      b8.out_ready = 8'hF7;
      #1;
      chk("bp_ready0", 32'(b8.in_ready), 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_valid", 32'(b8.out_valid), 32'h08);
         chk("bp_data", 32'(b8.out_data), 32'hA5);
         chk("bp_ready", 32'(b8.in_ready), 32'h0);
      end
      b8.out_ready = 8'hFF;
      #1;
      chk("rel_ready", 32'(b8.in_ready), 32'h1);
      step();
      chk("rel_valid", 32'(b8.out_valid), 32'h00);

      // streaming, one word per cycle
      for (int i = 0; i < 8; i++) begin
         drv8(1'b1, 8'h10 + 8'(i), 3'(i), 1'b0, 8'hFF);
         push(8'h10 + 8'(i), 8'h01 << i);
         step();
         pop_chk("stream");
         chk("stream_ready", 32'(b8.in_ready), 32'h1);
      end
      b8.in_valid = 1'b0;
      step();
      chk("stream_end", 32'(b8.out_valid), 32'h00);

      // broadcast with partial acceptance
      drv8(1'b1, 8'h3C, 3'd6, 1'b1, 8'h0F);
      push(8'h3C, 8'hFF);
      step();
      b8.in_valid = 1'b0;
      b8.in_bcast = 1'b0;
      pop_chk("bcast");
      step();
      chk("bcast_part_valid", 32'(b8.out_valid), 32'hF0);
      chk("bcast_part_data", 32'(b8.out_data), 32'h3C);
      chk("bcast_part_ready", 32'(b8.in_ready), 32'h0);
      b8.out_ready = 8'hF0;
      #1;
      chk("bcast_rest_ready", 32'(b8.in_ready), 32'h1);
      step();
      chk("bcast_done", 32'(b8.out_valid), 32'h00);
      drv8(1'b1, 8'h5A, 3'd1, 1'b0, 8'hFF);
      push(8'h5A, 8'h02);
      step();
      b8.in_valid = 1'b0;
      pop_chk("after_bcast");

      // reset while holding, with a coincident accept
      drv8(1'b1, 8'h77, 3'd5, 1'b0, 8'hFF);
      push(8'h77, 8'h20);
      step();
      b8.in_valid = 1'b0;
      pop_chk("hold_load");
      b8.out_ready = 8'h00;
      step();
      chk("hold_valid", 32'(b8.out_valid), 32'h20);
      rst = 1'b1;
      drv8(1'b1, 8'h99, 3'd2, 1'b0, 8'hFF);
      step();
      rst = 1'b0;
      b8.in_valid = 1'b0;
      chk("mid_rst_valid", 32'(b8.out_valid), 32'h00);
      chk("mid_rst_data", 32'(b8.out_data), 32'h00);
      chk("u8_no_drops", 32'(b8.drop_cnt), 32'h0);
      chk("sb_drained", 32'(sb.size()), 32'h0);

      // out-of-range selects on the 6-channel instance
      b6.in_valid = 1'b1;
      b6.in_data  = 8'h42;
      b6.in_sel   = 3'd2;
      step();
      b6.in_valid = 1'b0;
      chk("c6_load", 32'(b6.out_valid), 32'h04);
      step();
      chk("c6_done", 32'(b6.out_valid), 32'h00);
      b6.in_valid = 1'b1;
      b6.in_data  = 8'hEE;
      b6.in_sel   = 3'd7;
      step();
      b6.in_valid = 1'b0;
      chk("oor_err", 32'(b6.err_sel), 32'h1);
      chk("oor_cnt", 32'(b6.drop_cnt), 32'h1);
      chk("oor_valid", 32'(b6.out_valid), 32'h00);
      chk("oor_data", 32'(b6.out_data), 32'h42);
      step();
      chk("oor_err_clr", 32'(b6.err_sel), 32'h0);
      b6.in_valid = 1'b1;
      b6.in_sel   = 3'd6;
      step();
      b6.in_valid = 1'b0;
      chk("edge_err", 32'(b6.err_sel), 32'h1);
      chk("edge_cnt", 32'(b6.drop_cnt), 32'h2);
      b6.in_valid = 1'b1;
      b6.in_data  = 8'h61;
      b6.in_sel   = 3'd5;
      step();
      b6.in_valid = 1'b0;
      chk("top_valid", 32'(b6.out_valid), 32'h20);
      chk("top_err", 32'(b6.err_sel), 32'h0);
      chk("top_cnt", 32'(b6.drop_cnt), 32'h2);

      // back-to-back drops up to 2^16+5 in total
      b6.in_valid = 1'b1;
      b6.in_sel   = 3'd7;
      for (int i = 0; i < 65539; i++) begin
         step();
         if (i == 1) begin
            chk("b2b_err", 32'(b6.err_sel), 32'h1);
            chk("b2b_cnt", 32'(b6.drop_cnt), 32'h4);
         end
      end
      chk("sat_cnt", 32'(b6.drop_cnt), 32'hFFFF);
      chk("sat_err", 32'(b6.err_sel), 32'h1);
      b6.in_valid = 1'b0;
      step();
      chk("sat_hold", 32'(b6.drop_cnt), 32'hFFFF);
      chk("sat_err_clr", 32'(b6.err_sel), 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
